// File: rtl/uart_rx_stream.sv
// UART receiver with 3-sample majority voting, optional parity, 1/2 stop bits and a frame FIFO.
// Break detection is compiled in only when UART_RX_BREAK_EN is defined.
module uart_rx_stream #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 1_000_000,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    output logic [DATA_WIDTH+1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  overrun,
    output logic                  rx_break,
    output logic                  busy
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int BW  = $clog2(DATA_WIDTH + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int FW  = DATA_WIDTH + 2;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_DEC   = CW'(CPB / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t                state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [1:0]            samp_q, samp_d;
    logic                  par_err_q, par_err_d;
    logic                  frm_err_q, frm_err_d;
    logic                  stop_idx_q, stop_idx_d;
    logic                  armed_q, armed_d;
    logic                  overrun_q, overrun_d;
    logic                  rx_break_q, rx_break_d;
    logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]         mem_q [FIFO_DEPTH];
    logic [FW-1:0]         mem_d [FIFO_DEPTH];
    logic                  vote, push, brk_pulse, brk_hit, exp_par, full, pop, do_push;
    logic [FW-1:0]         push_data;

    // samp_q holds rx_s from the two previous cycles, so at CNT_DEC it covers mid-1 and mid
    assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign exp_par   = (PARITY == 1) ? ^shreg_q : ~^shreg_q;
    assign push_data = {frm_err_q | ~vote, par_err_q, shreg_q};
    assign busy      = (state_q != S_IDLE);

`ifdef UART_RX_BREAK_EN
    logic par_bit_q, par_bit_d;
    assign brk_hit = (stop_idx_q == 1'b0) && !vote && (shreg_q == '0) && !par_bit_q;
`else
    assign brk_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        samp_d     = {samp_q[0], rx_s_q};
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        stop_idx_d = stop_idx_q;
        armed_d    = armed_q;
        push       = 1'b0;
        brk_pulse  = 1'b0;
`ifdef UART_RX_BREAK_EN
        par_bit_d  = par_bit_q;
`endif
        if (state_q != S_IDLE)
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        case (state_q)
            S_IDLE: begin
                if (rx_s_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    // the detect cycle is sample 0 of the start bit
                    state_d    = S_START;
                    cnt_d      = CW'(1);
                    bit_cnt_d  = '0;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                    stop_idx_d = 1'b0;
                    armed_d    = 1'b0;
`ifdef UART_RX_BREAK_EN
                    par_bit_d  = 1'b0;
`endif
                end
            end
            S_START: begin
                if (cnt_q == CNT_DEC && vote) state_d = S_IDLE;
                else if (cnt_q == CNT_LAST)   state_d = S_DATA;
            end
            S_DATA: begin
                if (cnt_q == CNT_DEC) begin
                    shreg_d   = {vote, shreg_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end else if (cnt_q == CNT_LAST && bit_cnt_q == BIT_LAST) begin
                    state_d = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (cnt_q == CNT_DEC) begin
                    par_err_d = (vote != exp_par);
`ifdef UART_RX_BREAK_EN
                    par_bit_d = vote;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_DEC) begin
                    if (brk_hit) begin
                        brk_pulse = 1'b1;
                        state_d   = S_IDLE;
                        armed_d   = 1'b0;
                    end else begin
                        if (!vote) frm_err_d = 1'b1;
                        if (stop_idx_q == STOP_LAST) begin
                            push    = 1'b1;
                            state_d = S_IDLE;
                            armed_d = vote;
                        end
                    end
                end else if (cnt_q == CNT_LAST) begin
                    stop_idx_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // full is judged before any same-cycle pop, so a push into a full FIFO is always dropped
    always_comb begin
        full       = ((wr_ptr_q - rd_ptr_q) == FULL_CNT);
        m_valid    = (wr_ptr_q != rd_ptr_q);
        pop        = m_valid & m_ready;
        do_push    = push & ~full;
        overrun_d  = push & full;
        rx_break_d = brk_pulse;
        mem_d      = mem_q;
        if (do_push) mem_d[wr_ptr_q[AW-1:0]] = push_data;
        wr_ptr_d   = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
        m_data     = m_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    end

    assign overrun  = overrun_q;
    assign rx_break = rx_break_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            samp_q     <= 2'b11;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            stop_idx_q <= 1'b0;
            armed_q    <= 1'b0;
            overrun_q  <= 1'b0;
            rx_break_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_q      <= '{default: '0};
`ifdef UART_RX_BREAK_EN
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            samp_q     <= samp_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            stop_idx_q <= stop_idx_d;
            armed_q    <= armed_d;
            overrun_q  <= overrun_d;
            rx_break_q <= rx_break_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
`ifdef UART_RX_BREAK_EN
            par_bit_q  <= par_bit_d;
`endif
        end
    end
endmodule
